// File: rtl/mult_pipe_param.sv
// mult_pipe_param: pipelined shift-add multiplier, signed/unsigned per operation, tag sideband, global-stall handshake.
module mult_pipe_param #(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int TAG_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_signed,
   input  logic [A_WIDTH-1:0]           in_a,
   input  logic [B_WIDTH-1:0]           in_b,
   input  logic [TAG_WIDTH-1:0]         in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [A_WIDTH+B_WIDTH-1:0]   out_p,
   output logic [TAG_WIDTH-1:0]         out_tag,
   output logic                         busy
);
   localparam int P = A_WIDTH + B_WIDTH;

   logic [B_WIDTH-1:0]   v_q, v_d;
   logic [P-1:0]         p_q [B_WIDTH];
   logic [P-1:0]         p_d [B_WIDTH];
   logic [P-1:0]         a_q [B_WIDTH];
   logic [P-1:0]         a_d [B_WIDTH];
   logic [B_WIDTH-1:0]   b_q [B_WIDTH];
   logic [B_WIDTH-1:0]   b_d [B_WIDTH];
   logic                 s_q [B_WIDTH];
   logic                 s_d [B_WIDTH];
   logic [TAG_WIDTH-1:0] t_q [B_WIDTH];
   logic [TAG_WIDTH-1:0] t_d [B_WIDTH];
   logic                 adv;

   assign adv       = !v_q[B_WIDTH-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[B_WIDTH-1];
   assign out_p     = p_q[B_WIDTH-1];
   assign out_tag   = t_q[B_WIDTH-1];
   assign busy      = |v_q;

   // b_q holds the multiplier bits not yet consumed, next bit always at [0]
   assign v_d[0] = in_valid;
   assign a_d[0] = {{B_WIDTH{in_signed & in_a[A_WIDTH-1]}}, in_a};
   assign p_d[0] = in_b[0] ? a_d[0] : '0;
   assign b_d[0] = in_b >> 1;
   assign s_d[0] = in_signed;
   assign t_d[0] = in_tag;

   for (genvar k = 1; k < B_WIDTH; k++) begin : g_st
      logic [P-1:0] ash;
      assign ash    = a_q[k-1] << 1;
      assign a_d[k] = ash;
      assign b_d[k] = b_q[k-1] >> 1;
      assign v_d[k] = v_q[k-1];
      assign s_d[k] = s_q[k-1];
      assign t_d[k] = t_q[k-1];
      // the multiplier MSB carries negative weight in signed mode
      assign p_d[k] = !b_q[k-1][0] ? p_q[k-1] :
                      (k == B_WIDTH-1 && s_q[k-1]) ? p_q[k-1] - ash : p_q[k-1] + ash;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         p_q <= '{default: '0};
         a_q <= '{default: '0};
         b_q <= '{default: '0};
         s_q <= '{default: 1'b0};
         t_q <= '{default: '0};
      end else if (adv) begin
         v_q <= v_d;
         p_q <= p_d;
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
         t_q <= t_d;
      end
   end
endmodule

// File: tb/tb_mult_pipe_param.sv
// tb_mult_pipe_param: directed table vectors on a 16x16 instance, multi-cycle corner sequences on an 8x8 instance.
module tb_mult_pipe_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   logic        iv16 = 0, is16 = 0, or16 = 1, ir16, ov16, bz16;
   logic [15:0] a16 = 0, b16 = 0;
   logic [3:0]  t16 = 0, ot16;
   logic [31:0] p16;

   logic        iv8 = 0, is8 = 0, or8 = 1, ir8, ov8, bz8;
   logic [7:0]  a8 = 0, b8 = 0;
   logic [3:0]  t8 = 0, ot8;
   logic [15:0] p8;

   mult_pipe_param u16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_signed(is16),
      .in_a(a16), .in_b(b16), .in_tag(t16), .out_valid(ov16), .out_ready(or16),
      .out_p(p16), .out_tag(ot16), .busy(bz16)
   );

   mult_pipe_param #(.A_WIDTH(8), .B_WIDTH(8), .TAG_WIDTH(4)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
      .in_a(a8), .in_b(b8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
      .out_p(p8), .out_tag(ot8), .busy(bz8)
   );

   typedef struct {
      logic        sg;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  tag;
      logic [31:0] p;
   } vec_t;

   vec_t tv [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run16(input vec_t v, input int idx);
      int cnt;
      @(negedge clk);
      iv16 = 1; is16 = v.sg; a16 = v.a; b16 = v.b; t16 = v.tag;
      #1 chk($sformatf("ready16[%0d]", idx), 64'(ir16), 64'(1));
      @(negedge clk);
      iv16 = 0;
      cnt = 1;
      while (!ov16 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk($sformatf("lat16[%0d]", idx), 64'(cnt), 64'(16));
      chk($sformatf("p16[%0d]", idx), 64'(p16), 64'(v.p));
      chk($sformatf("tag16[%0d]", idx), 64'(ot16), 64'(v.tag));
   endtask

   task automatic wait8(input int start, output int cnt);
      cnt = start;
      while (!ov8 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt, sent, got;
      logic pend, stl;
      logic [15:0] hp;
      logic [3:0]  ht;
      logic [15:0] q_p [$];
      logic [3:0]  q_t [$];
      logic signed [7:0]  sa, sb;
      logic signed [15:0] pr;

      tv[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 4'h3, 32'hFFFE0001};
      tv[1] = '{1'b0, 16'h0000, 16'h1234, 4'h1, 32'h00000000};
      tv[2] = '{1'b1, 16'h0001, 16'h8000, 4'h2, 32'hFFFF8000};
      tv[3] = '{1'b0, 16'h0001, 16'h8000, 4'h4, 32'h00008000};
      tv[4] = '{1'b1, 16'h8000, 16'h8000, 4'h5, 32'h40000000};
      tv[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 4'h6, 32'h00000001};
      tv[6] = '{1'b0, 16'h1234, 16'h0010, 4'h7, 32'h00012340};
      tv[7] = '{1'b1, 16'hFFFD, 16'h0005, 4'h8, 32'hFFFFFFF1};
      tv[8] = '{1'b1, 16'h7FFF, 16'h8000, 4'h9, 32'hC0008000};
      tv[9] = '{1'b0, 16'h00FF, 16'h0101, 4'hA, 32'h0000FFFF};

      #1;
      chk("rst_ov16", 64'(ov16), 64'(0));
      chk("rst_busy16", 64'(bz16), 64'(0));
      chk("rst_ready16", 64'(ir16), 64'(1));
      chk("rst_p16", 64'(p16), 64'(0));
      chk("rst_tag16", 64'(ot16), 64'(0));
      chk("rst_ov8", 64'(ov8), 64'(0));
      chk("rst_busy8", 64'(bz8), 64'(0));
      chk("rst_ready8", 64'(ir8), 64'(1));
      repeat (2) @(negedge clk);
      rst = 0;

      for (int i = 0; i < 10; i++) run16(tv[i], i);

      // back-to-back mixed-mode issue on the 8x8 instance
      @(negedge clk); iv8 = 1; is8 = 1; a8 = 8'h80; b8 = 8'h80; t8 = 4'h1;
      @(negedge clk); iv8 = 1; is8 = 1; a8 = 8'hFD; b8 = 8'h05; t8 = 4'h2;
      @(negedge clk); iv8 = 1; is8 = 0; a8 = 8'hFD; b8 = 8'h05; t8 = 4'h3;
      @(negedge clk); iv8 = 0;
      wait8(3, cnt);
      chk("b2b_lat", 64'(cnt), 64'(8));
      chk("b2b_p0", 64'(p8), 64'(16'h4000));
      chk("b2b_t0", 64'(ot8), 64'(1));
      @(negedge clk);
      chk("b2b_v1", 64'(ov8), 64'(1));
      chk("b2b_p1", 64'(p8), 64'(16'hFFF1));
      chk("b2b_t1", 64'(ot8), 64'(2));
      @(negedge clk);
      chk("b2b_v2", 64'(ov8), 64'(1));
      chk("b2b_p2", 64'(p8), 64'(16'h04F1));
      chk("b2b_t2", 64'(ot8), 64'(3));
      @(negedge clk);
      chk("b2b_v3", 64'(ov8), 64'(0));

      // random backpressure with a queue-based reference
      sent = 0; got = 0; pend = 0; stl = 0; hp = 0; ht = 0;
      for (int c = 0; c < 600 && got < 20; c++) begin
         @(negedge clk);
         or8 = 1'($urandom_range(0, 1));
         if (!pend) begin
            if (sent < 20) begin
               iv8 = 1; is8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); t8 = 4'(sent); pend = 1;
            end else iv8 = 0;
         end
         #1;
         chk("bp_ready", 64'(ir8), 64'(!(ov8 && !or8)));
         if (stl) begin
            chk("bp_hold_v", 64'(ov8), 64'(1));
            chk("bp_hold_p", 64'(p8), 64'(hp));
            chk("bp_hold_t", 64'(ot8), 64'(ht));
         end
         stl = ov8 && !or8;
         hp = p8;
         ht = ot8;
         if (ov8 && or8) begin
            if (q_p.size() == 0) chk("bp_extra", 64'(1), 64'(0));
            else begin
               chk("bp_p", 64'(p8), 64'(q_p.pop_front()));
               chk("bp_t", 64'(ot8), 64'(q_t.pop_front()));
            end
            got++;
         end
         if (iv8 && ir8) begin
            sa = a8; sb = b8; pr = sa * sb;
            q_p.push_back(pr);
            q_t.push_back(t8);
            sent++;
            pend = 0;
         end
      end
      @(negedge clk);
      iv8 = 0; or8 = 1;
      chk("bp_got", 64'(got), 64'(20));
      chk("bp_left", 64'(q_p.size()), 64'(0));
      repeat (10) @(negedge clk);
      chk("bp_idle", 64'(bz8), 64'(0));

      // alternating valid/bubble pattern
      for (int m = 0; m < 22; m++) begin
         @(negedge clk);
         chk($sformatf("bub_v[%0d]", m), 64'(ov8), 64'(m >= 8 && m < 16 && m % 2 == 0));
         if (m >= 8 && m < 16 && m % 2 == 0) chk($sformatf("bub_p[%0d]", m), 64'(p8), 64'((m - 7) * 3));
         iv8 = (m < 8) && (m % 2 == 0); is8 = 0; a8 = 8'(m + 1); b8 = 8'd3; t8 = 4'(m);
      end

      // reset with the stalled pipeline holding five operations
      @(negedge clk);
      or8 = 0;
      for (int i = 0; i < 5; i++) begin
         iv8 = 1; is8 = 0; a8 = 8'(i + 2); b8 = 8'd9; t8 = 4'(i);
         @(negedge clk);
      end
      iv8 = 0;
      wait8(5, cnt);
      chk("mid_ov", 64'(ov8), 64'(1));
      chk("mid_busy", 64'(bz8), 64'(1));
      #2 rst = 1;
      #1;
      chk("arst_ov", 64'(ov8), 64'(0));
      chk("arst_busy", 64'(bz8), 64'(0));
      chk("arst_ready", 64'(ir8), 64'(1));
      chk("arst_p", 64'(p8), 64'(0));
      chk("arst_tag", 64'(ot8), 64'(0));
      repeat (2) @(negedge clk);
      rst = 0; or8 = 1;
      @(negedge clk);
      iv8 = 1; is8 = 0; a8 = 8'd7; b8 = 8'd6; t8 = 4'hC;
      @(negedge clk);
      iv8 = 0;
      wait8(1, cnt);
      chk("post_lat", 64'(cnt), 64'(8));
      chk("post_p", 64'(p8), 64'(42));
      chk("post_t", 64'(ot8), 64'(4'hC));
      @(negedge clk);
      chk("post_stale", 64'(ov8), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
